// File: rtl/common.sv
// Shared execute-stage types and constants, including the divider state encoding.
package common;

  typedef logic [31:0] word_t;
  typedef logic [63:0] dword_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } div_state_t;

  localparam int DIV_ITERS = 32;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, subtract if it fits.
module div_step
  import common::*;
#(
  parameter int WIDTH = DIV_ITERS
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;

  // The partial remainder stays below the divisor, so the top shifted bit is only kept for the compare.
  always_comb begin
    shifted  = {rem, dvd_msb};
    q_bit    = (shifted >= {2'b00, divisor});
    rem_next = q_bit ? (shifted[WIDTH:0] - {1'b0, divisor}) : shifted[WIDTH:0];
  end

endmodule

// File: rtl/divider_multicycle.sv
// Iterative radix-2 restoring DIV/DIVU: magnitudes over WIDTH cycles, then sign fix-up; done in cycle t+34.
// DIV_ZERO_FAST_EN: a zero divisor skips the iterations (done in cycle t+2, identical hi/lo).
module divider_multicycle
  import common::*;
#(
  parameter int WIDTH = DIV_ITERS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_t       state_q;
  div_state_t       state_d;

  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH:0]   rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             q_neg_q;
  logic             r_neg_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             zero_fast;

  logic             launch;
  logic             step;
  logic             finish;

  logic [WIDTH:0]   rem_next;
  logic             q_bit;

  always_comb begin
    a_neg = is_signed & a[WIDTH-1];
    b_neg = is_signed & b[WIDTH-1];
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;
  end

`ifdef DIV_ZERO_FAST_EN
  assign zero_fast = (b_mag == '0);
`else
  assign zero_fast = 1'b0;
`endif

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[WIDTH-1]),
    .divisor  (dsr_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          launch  = 1'b1;
          state_d = zero_fast ? SIGN : CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A cancel overrides everything, including a same-cycle start.
    if (flush) begin
      state_d = IDLE;
      launch  = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
    end
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= finish;
      if (launch) begin
        // The dividend register doubles as the quotient: bits shift out the top, quotient bits in the bottom.
        dvd_q   <= zero_fast ? '1 : a_mag;
        rem_q   <= zero_fast ? {1'b0, a_mag} : '0;
        dsr_q   <= b_mag;
        cnt_q   <= '0;
        q_neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        r_neg_q <= a_neg;
      end else if (step) begin
        dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
        rem_q <= rem_next;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (finish) begin
        lo <= q_neg_q ? (~dvd_q + 1'b1) : dvd_q;
        hi <= r_neg_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_divider_multicycle.sv
// Randomized and directed checks of divider_multicycle against a plain-arithmetic reference model.
module tb_divider_multicycle;

  logic        clk;
  logic        reset;
  logic        start;
  logic        flush;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks;
  int          errors;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  divider_multicycle #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .flush     (flush),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // MIPS DIV/DIVU: truncating quotient, remainder takes the dividend's sign; /0 gives |q|=all-ones, |r|=|a|.
  function automatic void model(input bit sgn, input logic [31:0] av, input logic [31:0] bv,
                                output logic [31:0] q, output logic [31:0] r);
    logic [31:0] ma, mb, mq, mr;
    bit an, bn;
    an = sgn && av[31];
    bn = sgn && bv[31];
    ma = an ? 32'(0 - av) : av;
    mb = bn ? 32'(0 - bv) : bv;
    if (mb == 0) begin
      mq = 32'hFFFF_FFFF;
      mr = ma;
    end else begin
      mq = ma / mb;
      mr = ma % mb;
    end
    q = (an ^ bn) ? 32'(0 - mq) : mq;
    r = an ? 32'(0 - mr) : mr;
  endfunction

  // Called at #1 after a rising edge; that cycle is cycle 0 and carries the start request.
  task automatic run_op(input bit sgn, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eq, input logic [31:0] er,
                        input int flush_at, input int restart_at);
    int   lat;
    int   done_at;
    int   busy_cnt;
    logic busy_post_flush;
    logic busy_at_done;
    lat = 34;
`ifdef DIV_ZERO_FAST_EN
    if (bv == 0) lat = 2;
`endif
    is_signed = sgn;
    a         = av;
    b         = bv;
    start     = 1'b1;
    flush     = (flush_at == 0);
    done_at         = 0;
    busy_cnt        = 0;
    busy_post_flush = 1'b1;
    busy_at_done    = 1'b1;
    for (int n = 1; n <= 60 && done_at == 0; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_at      = n;
        busy_at_done = busy;
      end else if (busy) begin
        busy_cnt++;
      end
      if (n == flush_at + 1) busy_post_flush = busy;
      start = (n == restart_at);
      flush = (n == flush_at);
      if (n == restart_at) begin
        is_signed = ~sgn;
        a         = ~av;
        b         = bv + 32'd3;
      end
    end
    start = 1'b0;
    flush = 1'b0;
    if (flush_at >= 0) begin
      check("flush_no_done", done_at, 0);
      check("flush_busy_after", {31'd0, busy_post_flush}, 0);
      check("flush_hi_kept", hi, exp_hi);
      check("flush_lo_kept", lo, exp_lo);
    end else begin
      check("done_cycle", done_at, lat);
      check("busy_cycles", busy_cnt, lat - 1);
      check("busy_at_done", {31'd0, busy_at_done}, 0);
      check("hi", hi, er);
      check("lo", lo, eq);
      exp_hi = er;
      exp_lo = eq;
    end
  endtask

  initial begin
    logic [31:0] av, bv, eq, er;
    bit          sg;
    int          sel;
    checks    = 0;
    errors    = 0;
    exp_hi    = '0;
    exp_lo    = '0;
    reset     = 1'b1;
    start     = 1'b0;
    flush     = 1'b0;
    is_signed = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases; back-to-back calls also exercise start in the done cycle.
    run_op(1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        -1, -1);
    run_op(1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, -1, -1);
    run_op(1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        -1, -1);
    run_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        -1, -1);
    run_op(1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0,        -1, -1);
    run_op(1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,        -1, -1);
    run_op(1'b1, 32'hFFFF_FFFB,  32'd0,        32'd1,         32'hFFFF_FFFB, -1, -1);
    run_op(1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        -1, 10);

    // Cancel mid-CALC, then start and flush together.
    run_op(1'b1, 32'd12345, 32'd67, 32'd0, 32'd0, 20, -1);
    run_op(1'b0, 32'd999,   32'd4,  32'd0, 32'd0, 0,  -1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("hold_hi", hi, exp_hi);
    check("hold_lo", lo, exp_lo);

    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 7);
      sg  = 1'($urandom_range(0, 1));
      av  = $urandom;
      case (sel)
        0:       bv = 32'd0;
        1, 2:    bv = $urandom_range(1, 20);
        3:       bv = 32'hFFFF_FFFF - $urandom_range(0, 20);
        4: begin
          av = $urandom_range(0, 100);
          bv = $urandom_range(1, 200);
        end
        default: bv = $urandom >> $urandom_range(0, 31);
      endcase
      model(sg, av, bv, eq, er);
      run_op(sg, av, bv, eq, er, -1, -1);
      if (i % 3 == 0) begin
        repeat (2) begin
          @(posedge clk);
          #1;
        end
      end
    end

    // Asynchronous reset in the middle of CALC.
    is_signed = 1'b0;
    a         = 32'd1000;
    b         = 32'd3;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 0);
    check("arst_done", {31'd0, done}, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
